// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multiplexed six-digit seven-segment scan driver for an
// HH:MM:SS clock. Each digit slot lasts DIV clocks; the first BLANK clocks of
// every slot are dark to suppress ghosting between digits. All six BCD digits
// are snapshotted once per frame so a frame always shows one coherent time.
// All outputs are registered and active-low.
//
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking
// of the tens-of-hours digit (slot 5). Without it, a zero there shows "0".
module seg_scan_drv #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] m_hr,
  input  logic [3:0] l_hr,
  input  logic [3:0] m_min,
  input  logic [3:0] l_min,
  input  logic [3:0] m_sec,
  input  logic [3:0] l_sec,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLANK_C = CW'(BLANK);
  localparam logic [2:0]     IDX_MAX = 3'd5;
  localparam logic [5:0]     AN_OFF  = 6'b111111;
  localparam logic [6:0]     SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  // Snapshot layout: slot k occupies bits [4k+3:4k].
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   snap_q, snap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit_s;
  logic          lit_s;

  // Scan position and frame snapshot; everything holds while en is low.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q >= IDX_MAX) begin
          idx_d  = 3'd0;
          snap_d = {m_hr, l_hr, m_min, l_min, m_sec, l_sec};
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Select the snapshot digit belonging to the current slot.
  always_comb begin
    digit_s = 4'd0;
    case (idx_q)
      3'd0:    digit_s = snap_q[3:0];
      3'd1:    digit_s = snap_q[7:4];
      3'd2:    digit_s = snap_q[11:8];
      3'd3:    digit_s = snap_q[15:12];
      3'd4:    digit_s = snap_q[19:16];
      3'd5:    digit_s = snap_q[23:20];
      default: digit_s = 4'd0;
    endcase
  end

  // Output pattern for the current cnt/idx; dark when disabled or in the
  // ghost-blanking window at the start of each slot.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    lit_s = en && (cnt_q >= BLANK_C) && (idx_q <= IDX_MAX);
`ifdef SEG_SCAN_LZB_EN
    if ((idx_q == IDX_MAX) && (digit_s == 4'd0)) begin
      lit_s = 1'b0;
    end else begin
      lit_s = lit_s;
    end
`endif
    if (lit_s) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = seg_decode(digit_s);
      dp_d  = ~((idx_q == 3'd2) || (idx_q == 3'd4));
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= 24'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv with DIV=4, BLANK=1. A cycle model
// pushes the expected {an,seg,dp} for each driven clock onto a queue, which
// is popped and compared after the edge; directed checks pin key values.
module tb_seg_scan_drv;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] m_hr, l_hr, m_min, l_min, m_sec, l_sec;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         mcnt, midx;
  logic [3:0] msnap [0:5];
  logic [13:0] sbq [$];

  logic [6:0] dec_tab [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  // Second-frame expectations for 12:34:56
  logic [5:0] an_tab  [0:5] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
  logic [6:0] seg_tab [0:5] = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic       dp_tab  [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  seg_scan_drv #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .m_hr(m_hr), .l_hr(l_hr), .m_min(m_min), .l_min(l_min),
    .m_sec(m_sec), .l_sec(l_sec),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict, push, clock, pop/compare, advance the model.
  task automatic step();
    logic [5:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic        lit;
    logic [13:0] e;
    an_e = 6'b111111; seg_e = 7'b1111111; dp_e = 1'b1;
    lit = !rst && en && (mcnt >= BLANK);
`ifdef SEG_SCAN_LZB_EN
    if (midx == 5 && msnap[5] == 4'd0) lit = 1'b0;
`endif
    if (lit) begin
      an_e  = ~(6'd1 << midx);
      seg_e = dec_tab[msnap[midx]];
      dp_e  = !(midx == 2 || midx == 4);
    end
    sbq.push_back({an_e, seg_e, dp_e});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_an",  {26'd0, an},  {26'd0, e[13:8]});
    chk("sb_seg", {25'd0, seg}, {25'd0, e[7:1]});
    chk("sb_dp",  {31'd0, dp},  {31'd0, e[0]});
    if ((an & (an - 6'd1)) !== 6'd0 && an !== 6'b111111 && (~an & (~an - 6'd1)) !== 6'd0)
      chk("onehot_an", {26'd0, an}, 32'h3F);
    if (rst) begin
      mcnt = 0; midx = 0;
      for (int k = 0; k < 6; k++) msnap[k] = 4'd0;
    end else if (en) begin
      if (mcnt == DIV - 1) begin
        mcnt = 0;
        if (midx == 5) begin
          midx = 0;
          msnap[0] = l_sec; msnap[1] = m_sec; msnap[2] = l_min;
          msnap[3] = m_min; msnap[4] = l_hr;  msnap[5] = m_hr;
        end else begin
          midx = midx + 1;
        end
      end else begin
        mcnt = mcnt + 1;
      end
    end
  endtask

  task automatic run_to(input int i, input int c);
    for (int k = 0; k < 200 && !(midx == i && mcnt == c); k++) step();
    chk("run_to", {31'd0, (midx == i && mcnt == c)}, 32'd1);
  endtask

  initial begin
    mcnt = 0; midx = 0;
    for (int k = 0; k < 6; k++) msnap[k] = 4'd0;
    rst = 1'b1; en = 1'b1;
    m_hr = 4'd1; l_hr = 4'd2; m_min = 4'd3; l_min = 4'd4; m_sec = 4'd5; l_sec = 4'd6;

    // Reset held three clocks, then first clock after release is blank
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_an", {26'd0, an}, 32'h3F);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
    end
    rst = 1'b0;
    step();
    chk("post_rst_an", {26'd0, an}, 32'h3F);
    chk("post_rst_dp", {31'd0, dp}, 32'd1);

    // First frame shows zeros; verify second frame order
    run_to(0, 0);
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < DIV; c++) begin
        step();
        if (c < BLANK) begin
          chk("scan_blank_an", {26'd0, an}, 32'h3F);
        end else begin
          chk("scan_an",  {26'd0, an},  {26'd0, an_tab[s]});
          chk("scan_seg", {25'd0, seg}, {25'd0, seg_tab[s]});
          chk("scan_dp",  {31'd0, dp},  {31'd0, dp_tab[s]});
        end
      end
    end

    // Snapshot coherence: l_sec changes mid-frame, shows only next frame
    step(); step();
    chk("coh_old_seg", {25'd0, seg}, {25'd0, 7'b0000010});
    run_to(2, 0);
    l_sec = 4'd7;
    run_to(4, 1);
    step();
    chk("coh_frame_seg", {25'd0, seg}, {25'd0, 7'b0100100});
    run_to(0, 0);
    step(); step();
    chk("coh_new_seg", {25'd0, seg}, {25'd0, 7'b1111000});

    // Invalid BCD shows dash, separator dp still on
    l_min = 4'hA;
    run_to(0, 0);
    run_to(2, 1);
    step();
    chk("bcd_seg", {25'd0, seg}, {25'd0, 7'b0111111});
    chk("bcd_dp",  {31'd0, dp},  32'd0);

    // Leading zero on tens-of-hours
    m_hr = 4'd0;
    run_to(0, 0);
    run_to(5, 1);
    step();
`ifdef SEG_SCAN_LZB_EN
    chk("lzb_an",  {26'd0, an},  32'h3F);
    chk("lzb_seg", {25'd0, seg}, 32'h7F);
`else
    chk("lz_an",   {26'd0, an},  {26'd0, 6'b011111});
    chk("lz_seg",  {25'd0, seg}, {25'd0, 7'b1000000});
`endif

    // Enable drop at idx=3, cnt=2, then resume
    run_to(3, 2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("en_off_an", {26'd0, an}, 32'h3F);
      chk("en_off_dp", {31'd0, dp}, 32'd1);
    end
    en = 1'b1;
    step(); chk("en_res0_an", {26'd0, an}, {26'd0, 6'b110111});
    step(); chk("en_res1_an", {26'd0, an}, {26'd0, 6'b110111});
    step(); chk("en_res2_an", {26'd0, an}, 32'h3F);
    step(); chk("en_res3_an", {26'd0, an}, {26'd0, 6'b101111});

    // Mid-frame reset aborts scan; next frame shows zero snapshot
    run_to(2, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_an", {26'd0, an}, 32'h3F);
    rst = 1'b0;
    step(); step();
    chk("mid_rst_slot0_an",  {26'd0, an},  {26'd0, 6'b111110});
    chk("mid_rst_slot0_seg", {25'd0, seg}, {25'd0, 7'b1000000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
